clk_en_gen: RTL

Parametrised multi-rate strobe generator for the DSP datapath. It produces three nested, single-cycle clock-enable strobes from one clock: system, sample and symbol. No derived clock is generated. Divide ratios are run-time programmable through a valid/ready config port and take effect glitch-free at the next symbol boundary. A resync input realigns all strobes to an external symbol boundary. The block feeds the pulse-shaping filters, upsamplers and symbol mappers, which all run on `clk`.

---
 rtl/clk_en_pkg.sv | 15 +
 rtl/mod_cnt.sv | 42 ++++
 rtl/clk_en_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clk_en_pkg.sv
// Shared constants and the divisor-set payload for the multi-rate strobe generator.
package clk_en_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned SYS_DIV_DEF = 2;
  localparam int unsigned SAM_DIV_DEF = 4;
  localparam int unsigned SYM_DIV_DEF = 4;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] sys;
    logic [CNT_W_DEF-1:0] sam;
    logic [CNT_W_DEF-1:0] sym;
  } div_cfg_t;

endpackage

// File: rtl/mod_cnt.sv
// Enabled modulo counter with clear; wrap_c flags the enabled terminal count.
module mod_cnt
  import clk_en_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // >= compare so a count left above a smaller divisor still wraps
  always_comb begin
    wrap_c = en && (cnt_q >= (div - W'(1)));
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/clk_en_gen.sv
// Nested sys/sample/symbol clock-enable strobes with a boundary-synchronous config port.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYS_DIV_RST = SYS_DIV_DEF,
  parameter int unsigned SAM_DIV_RST = SAM_DIV_DEF,
  parameter int unsigned SYM_DIV_RST = SYM_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             resync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_sys_div,
  input  logic [CNT_W-1:0] cfg_sam_div,
  input  logic [CNT_W-1:0] cfg_sym_div,
  output logic             cfg_err,
  output logic             sys_en,
  output logic             sam_en,
  output logic             sym_en,
  output logic [CNT_W-1:0] sam_idx
);

  localparam int unsigned DW = CNT_W_DEF;
  localparam div_cfg_t DIV_RST = '{sys: DW'(SYS_DIV_RST),
                                   sam: DW'(SAM_DIV_RST),
                                   sym: DW'(SYM_DIV_RST)};

  div_cfg_t active_q, active_d;
  div_cfg_t pend_q, pend_d;
  div_cfg_t cfg_in;
  logic     pend_vld_q, pend_vld_d;
  logic     cfg_ready_q, cfg_ready_d;
  logic     cfg_err_q, cfg_err_d;
  logic     sys_en_q, sys_en_d;
  logic     sam_en_q, sam_en_d;
  logic     sym_en_q, sym_en_d;

  logic     cfg_ok_c, accept_c, reject_c, hold_apply_c, cnt_clr_c;
  logic     sys_wrap_c, sam_wrap_c, sym_wrap_c;
  logic [CNT_W-1:0] sys_cnt, sam_cnt, sym_cnt;
  logic     cnt_unused;

  mod_cnt #(.W(CNT_W)) u_sys_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr_c),
    .en     (run),
    .div    (CNT_W'(active_q.sys)),
    .cnt    (sys_cnt),
    .wrap_c (sys_wrap_c)
  );

  mod_cnt #(.W(CNT_W)) u_sam_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr_c),
    .en     (sys_wrap_c),
    .div    (CNT_W'(active_q.sam)),
    .cnt    (sam_cnt),
    .wrap_c (sam_wrap_c)
  );

  mod_cnt #(.W(CNT_W)) u_sym_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr_c),
    .en     (sam_wrap_c),
    .div    (CNT_W'(active_q.sym)),
    .cnt    (sym_cnt),
    .wrap_c (sym_wrap_c)
  );

  // Only the symbol-level count is visible; the inner counts drive wraps alone.
  assign cnt_unused = ^{sys_cnt, sam_cnt};

  // Handshake, pending/active divisor selection and strobe next-state.
  always_comb begin
    cfg_in = '{sys: DW'(cfg_sys_div), sam: DW'(cfg_sam_div), sym: DW'(cfg_sym_div)};
    cfg_ok_c = (cfg_sys_div != '0) && (cfg_sam_div != '0) && (cfg_sym_div != '0);
    accept_c = cfg_valid && cfg_ready_q && cfg_ok_c;
    reject_c = cfg_valid && cfg_ready_q && !cfg_ok_c;
    hold_apply_c = pend_vld_q && !run && !resync;
    cnt_clr_c = resync || hold_apply_c;

    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (resync) begin
      if (accept_c) begin
        active_d = cfg_in;
      end else if (pend_vld_q) begin
        active_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (pend_vld_q && (sym_wrap_c || !run)) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end else if (accept_c) begin
      pend_d     = cfg_in;
      pend_vld_d = 1'b1;
    end

    // Ready reopens one cycle after the pending set has been consumed.
    cfg_ready_d = !pend_vld_q && !accept_c;
    cfg_err_d   = reject_c;

    sys_en_d = sys_wrap_c && !resync;
    sam_en_d = sam_wrap_c && !resync;
    sym_en_d = sym_wrap_c && !resync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= DIV_RST;
      pend_q      <= DIV_RST;
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      sys_en_q    <= 1'b0;
      sam_en_q    <= 1'b0;
      sym_en_q    <= 1'b0;
    end else begin
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      sys_en_q    <= sys_en_d;
      sam_en_q    <= sam_en_d;
      sym_en_q    <= sym_en_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign sys_en    = sys_en_q;
  assign sam_en    = sam_en_q;
  assign sym_en    = sym_en_q;
  assign sam_idx   = sym_cnt;

endmodule
